// File: rtl/fifo_sync_param_if.sv
// Handshake bundle between a producer/consumer and fifo_sync_param.
// The master side drives write/read requests; the slave side (the FIFO) returns data and status flags.
interface fifo_sync_param_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] fifo_data_in;
  logic              fifo_write;
  logic              fifo_read;
  logic [DATA_W-1:0] fifo_data_out;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_afull;
  logic              fifo_aempty;

  modport master (
    output fifo_data_in, fifo_write, fifo_read,
    input  fifo_data_out, fifo_full, fifo_empty, fifo_afull, fifo_aempty
  );

  modport slave (
    input  fifo_data_in, fifo_write, fifo_read,
    output fifo_data_out, fifo_full, fifo_empty, fifo_afull, fifo_aempty
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with almost-full/almost-empty thresholds and exported pointers/count.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow error registers.
module fifo_sync_param #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 4
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              err_clr,
  fifo_sync_param_if.slave  bus,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W:0]   cnt,
  output logic              fifo_overflow,
  output logic              fifo_underflow
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;

  logic full;
  logic empty;
  logic rd_ok;
  logic wr_ok;

  // Flags decode only the registered count, so no input reaches them combinationally.
  assign full  = (cnt_q == DEPTH_C);
  assign empty = (cnt_q == '0);

  always_comb begin
    rd_ok      = bus.fifo_read && !empty;
    wr_ok      = bus.fifo_write && (!full || rd_ok);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_ok) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      data_out_d = mem_q[rd_ptr_q];
    end

    case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage is deliberately left out of reset; stale words are unreachable until rewritten.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= bus.fifo_data_in;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A new event wins over a same-cycle clear so no error is ever lost.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (bus.fifo_write && full && !bus.fifo_read) begin
      overflow_d = 1'b1;
    end
    if (bus.fifo_read && empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign fifo_overflow  = overflow_q;
  assign fifo_underflow = underflow_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign fifo_overflow  = 1'b0;
  assign fifo_underflow = 1'b0;
`endif

  assign wr_ptr            = wr_ptr_q;
  assign rd_ptr            = rd_ptr_q;
  assign cnt               = cnt_q;
  assign bus.fifo_data_out = data_out_q;
  assign bus.fifo_full     = full;
  assign bus.fifo_empty    = empty;
  assign bus.fifo_afull    = (cnt_q >= AFULL_C);
  assign bus.fifo_aempty   = (cnt_q <= AEMPTY_C);

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: default 16x16 instance against a queue model,
// plus an 8-bit x 8-deep instance for pointer wrap. Honours FIFO_ERR_FLAGS_EN like the RTL.
module tb_fifo_sync_param;

`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  logic err_clr = 1'b0;

  fifo_sync_param_if #(.DATA_W(16)) bus ();
  fifo_sync_param_if #(.DATA_W(8))  bus8 ();

  logic [3:0] wr_ptr, rd_ptr;
  logic [4:0] cnt;
  logic       ovf, unf;
  logic [2:0] wr_ptr8, rd_ptr8;
  logic [3:0] cnt8;
  logic       ovf8, unf8;

  fifo_sync_param dut (
    .clk(clk), .rst_(rst_), .err_clr(err_clr), .bus(bus),
    .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .cnt(cnt),
    .fifo_overflow(ovf), .fifo_underflow(unf)
  );

  fifo_sync_param #(.DATA_W(8), .ADDR_W(3), .AFULL_TH(6), .AEMPTY_TH(2)) dut8 (
    .clk(clk), .rst_(rst_), .err_clr(err_clr), .bus(bus8),
    .wr_ptr(wr_ptr8), .rd_ptr(rd_ptr8), .cnt(cnt8),
    .fifo_overflow(ovf8), .fifo_underflow(unf8)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: contents as a queue, pointers as totals of accepted operations.
  logic [15:0] mq[$];
  logic [15:0] m_dout;
  int          m_wr, m_rd;
  bit          m_ovf, m_unf;

  task automatic model_reset();
    mq.delete();
    m_dout = '0;
    m_wr = 0;
    m_rd = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic step(input bit w, input bit r, input bit c, input logic [15:0] d);
    bit rok, wok, was_full, was_empty;
    bus.fifo_write = w;
    bus.fifo_read = r;
    bus.fifo_data_in = d;
    err_clr = c;
    @(posedge clk);
    was_full = (mq.size() == 16);
    was_empty = (mq.size() == 0);
    rok = r && !was_empty;
    wok = w && (!was_full || rok);
    if (w && was_full && !r) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    if (r && was_empty) m_unf = 1'b1;
    else if (c) m_unf = 1'b0;
    if (rok) begin
      m_dout = mq.pop_front();
      m_rd++;
    end
    if (wok) begin
      mq.push_back(d);
      m_wr++;
    end
    #1;
    bus.fifo_write = 1'b0;
    bus.fifo_read = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic step8(input bit w, input bit r, input logic [7:0] d);
    bus8.fifo_write = w;
    bus8.fifo_read = r;
    bus8.fifo_data_in = d;
    @(posedge clk);
    #1;
    bus8.fifo_write = 1'b0;
    bus8.fifo_read = 1'b0;
  endtask

  task automatic test_reset();
    rst_ = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_ = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    n_checks++;
    if ({cnt, wr_ptr, rd_ptr, bus.fifo_empty, bus.fifo_full, bus.fifo_aempty, bus.fifo_afull} !== {5'd0, 4'd0, 4'd0, 4'b1010})
      $display("[TB] FAIL reset_state: got cnt=%0d wp=%0d rp=%0d e/f/ae/af=%b%b%b%b expected 0 0 0 1010",
               cnt, wr_ptr, rd_ptr, bus.fifo_empty, bus.fifo_full, bus.fifo_aempty, bus.fifo_afull);
    else n_pass++;
    n_checks++;
    if ({bus.fifo_data_out, ovf, unf} !== 18'd0)
      $display("[TB] FAIL reset_dout_err: got %h %b%b expected 0000 00", bus.fifo_data_out, ovf, unf);
    else n_pass++;

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 16'h00A0 + 16'(i));
    step(1'b0, 1'b1, 1'b0, 16'h0);
    n_checks++;
    if (cnt !== 5'd4 || bus.fifo_data_out !== 16'h00A0)
      $display("[TB] FAIL pre_reset: got cnt=%0d dout=%h expected 4 00a0", cnt, bus.fifo_data_out);
    else n_pass++;

    #2 rst_ = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({cnt, wr_ptr, rd_ptr, bus.fifo_empty, bus.fifo_full, bus.fifo_aempty, bus.fifo_afull, bus.fifo_data_out} !== {5'd0, 4'd0, 4'd0, 4'b1010, 16'h0})
      $display("[TB] FAIL midcycle_reset: got cnt=%0d wp=%0d rp=%0d flags=%b%b%b%b dout=%h expected 0 0 0 1010 0000",
               cnt, wr_ptr, rd_ptr, bus.fifo_empty, bus.fifo_full, bus.fifo_aempty, bus.fifo_afull, bus.fifo_data_out);
    else n_pass++;
    @(negedge clk) rst_ = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'(i));
      n_checks++;
      if (cnt !== 5'(i + 1) || bus.fifo_afull !== (i + 1 >= 12) || bus.fifo_full !== (i + 1 == 16))
        $display("[TB] FAIL fill_flags: got cnt=%0d af=%b f=%b expected %0d %b %b",
                 cnt, bus.fifo_afull, bus.fifo_full, i + 1, (i + 1 >= 12), (i + 1 == 16));
      else n_pass++;
    end
    n_checks++;
    if (wr_ptr !== 4'd0) $display("[TB] FAIL fill_wrptr: got %0d expected 0", wr_ptr);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0);
      n_checks++;
      if (bus.fifo_data_out !== 16'(i) || bus.fifo_aempty !== (15 - i <= 4) || bus.fifo_empty !== (i == 15))
        $display("[TB] FAIL drain_order: got dout=%h ae=%b e=%b expected %h %b %b",
                 bus.fifo_data_out, bus.fifo_aempty, bus.fifo_empty, 16'(i), (15 - i <= 4), (i == 15));
      else n_pass++;
    end
    n_checks++;
    if (rd_ptr !== 4'd0) $display("[TB] FAIL drain_rdptr: got %0d expected 0", rd_ptr);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [3:0] wp_before;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 16'($urandom));
    wp_before = wr_ptr;
    step(1'b1, 1'b0, 1'b0, 16'hDEAD);
    n_checks++;
    if (wr_ptr !== wp_before || cnt !== 5'd16 || ovf !== ERR_EN)
      $display("[TB] FAIL overflow_event: got wp=%0d cnt=%0d ovf=%b expected %0d 16 %b", wr_ptr, cnt, ovf, wp_before, ERR_EN);
    else n_pass++;
    repeat (3) step(1'b0, 1'b0, 1'b0, 16'h0);
    n_checks++;
    if (ovf !== ERR_EN) $display("[TB] FAIL overflow_sticky: got %b expected %b", ovf, ERR_EN);
    else n_pass++;
    step(1'b0, 1'b0, 1'b1, 16'h0);
    n_checks++;
    if (ovf !== 1'b0) $display("[TB] FAIL overflow_clear: got %b expected 0", ovf);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0);
      n_checks++;
      if (bus.fifo_data_out !== m_dout) $display("[TB] FAIL overflow_drain: got %h expected %h", bus.fifo_data_out, m_dout);
      else n_pass++;
    end
  endtask

  task automatic test_underflow();
    logic [15:0] held;
    logic [3:0]  rp_before;
    held = m_dout;
    rp_before = 4'(m_rd);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    n_checks++;
    if (rd_ptr !== rp_before || bus.fifo_data_out !== held || unf !== ERR_EN || cnt !== 5'd0)
      $display("[TB] FAIL underflow_event: got rp=%0d dout=%h unf=%b cnt=%0d expected %0d %h %b 0",
               rd_ptr, bus.fifo_data_out, unf, cnt, rp_before, held, ERR_EN);
    else n_pass++;
    step(1'b0, 1'b1, 1'b1, 16'h0);
    n_checks++;
    if (unf !== ERR_EN) $display("[TB] FAIL underflow_set_priority: got %b expected %b", unf, ERR_EN);
    else n_pass++;
    step(1'b0, 1'b0, 1'b1, 16'h0);
    n_checks++;
    if (unf !== 1'b0) $display("[TB] FAIL underflow_clear: got %b expected 0", unf);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [3:0]  wp_before, rp_before;
    logic [15:0] oldest, held;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 16'($urandom));
    wp_before = wr_ptr;
    rp_before = rd_ptr;
    oldest = mq[0];
    step(1'b1, 1'b1, 1'b0, 16'hBEEF);
    n_checks++;
    if (cnt !== 5'd16 || wr_ptr !== wp_before + 4'd1 || rd_ptr !== rp_before + 4'd1 || bus.fifo_data_out !== oldest || ovf !== 1'b0)
      $display("[TB] FAIL full_rw: got cnt=%0d wp=%0d rp=%0d dout=%h ovf=%b expected 16 %0d %0d %h 0",
               cnt, wr_ptr, rd_ptr, bus.fifo_data_out, ovf, wp_before + 4'd1, rp_before + 4'd1, oldest);
    else n_pass++;
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
    n_checks++;
    if (bus.fifo_data_out !== 16'hBEEF || bus.fifo_empty !== 1'b1)
      $display("[TB] FAIL full_rw_drain: got dout=%h e=%b expected beef 1", bus.fifo_data_out, bus.fifo_empty);
    else n_pass++;
    rp_before = rd_ptr;
    held = bus.fifo_data_out;
    step(1'b1, 1'b1, 1'b0, 16'h1234);
    n_checks++;
    if (cnt !== 5'd1 || rd_ptr !== rp_before || bus.fifo_data_out !== held || bus.fifo_empty !== 1'b0)
      $display("[TB] FAIL empty_rw: got cnt=%0d rp=%0d dout=%h e=%b expected 1 %0d %h 0",
               cnt, rd_ptr, bus.fifo_data_out, bus.fifo_empty, rp_before, held);
    else n_pass++;
    step(1'b0, 1'b1, 1'b0, 16'h0);
    n_checks++;
    if (bus.fifo_data_out !== 16'h1234) $display("[TB] FAIL empty_rw_read: got %h expected 1234", bus.fifo_data_out);
    else n_pass++;
    step(1'b0, 1'b0, 1'b1, 16'h0);
  endtask

  task automatic test_random();
    logic [16:0] got_v, exp_v;
    int wr_pct;
    for (int n = 0; n < 600; n++) begin
      wr_pct = ((n / 100) % 2 == 0) ? 75 : 25;
      step($urandom_range(99) < wr_pct, $urandom_range(99) < (100 - wr_pct), $urandom_range(19) == 0, 16'($urandom));
      got_v = {cnt, wr_ptr, rd_ptr, bus.fifo_full, bus.fifo_empty, bus.fifo_afull, bus.fifo_aempty};
      exp_v = {5'(mq.size()), 4'(m_wr), 4'(m_rd), mq.size() == 16, mq.size() == 0, mq.size() >= 12, mq.size() <= 4};
      n_checks++;
      if (got_v !== exp_v) $display("[TB] FAIL random_state: cycle %0d got %h expected %h", n, got_v, exp_v);
      else n_pass++;
      n_checks++;
      if ({bus.fifo_data_out, ovf, unf} !== {m_dout, ERR_EN & m_ovf, ERR_EN & m_unf})
        $display("[TB] FAIL random_data_err: cycle %0d got %h %b%b expected %h %b%b", n,
                 bus.fifo_data_out, ovf, unf, m_dout, ERR_EN & m_ovf, ERR_EN & m_unf);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      step8(1'b1, 1'b0, d);
      step8(1'b0, 1'b1, 8'h0);
      n_checks++;
      if (bus8.fifo_data_out !== d || wr_ptr8 !== 3'((i + 1) % 8) || rd_ptr8 !== 3'((i + 1) % 8) || cnt8 !== 4'd0)
        $display("[TB] FAIL wrap_pair: i=%0d got dout=%h wp=%0d rp=%0d cnt=%0d expected %h %0d %0d 0",
                 i, bus8.fifo_data_out, wr_ptr8, rd_ptr8, cnt8, d, (i + 1) % 8, (i + 1) % 8);
      else n_pass++;
    end
    for (int i = 0; i < 8; i++) begin
      step8(1'b1, 1'b0, 8'(i));
      n_checks++;
      if (cnt8 !== 4'(i + 1) || bus8.fifo_full !== (i == 7) || bus8.fifo_afull !== (i + 1 >= 6) || bus8.fifo_aempty !== (i + 1 <= 2))
        $display("[TB] FAIL wrap_fill: got cnt=%0d f=%b af=%b ae=%b expected %0d %b %b %b",
                 cnt8, bus8.fifo_full, bus8.fifo_afull, bus8.fifo_aempty, i + 1, (i == 7), (i + 1 >= 6), (i + 1 <= 2));
      else n_pass++;
    end
    for (int i = 0; i < 8; i++) begin
      step8(1'b0, 1'b1, 8'h0);
      n_checks++;
      if (bus8.fifo_data_out !== 8'(i)) $display("[TB] FAIL wrap_drain: got %h expected %h", bus8.fifo_data_out, 8'(i));
      else n_pass++;
    end
  endtask

  initial begin
    bus.fifo_write = 1'b0;
    bus.fifo_read = 1'b0;
    bus.fifo_data_in = '0;
    bus8.fifo_write = 1'b0;
    bus8.fifo_read = 1'b0;
    bus8.fifo_data_in = '0;
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised synchronous FIFO; next generation of the team's fixed 16×16 FIFO. Adds configurable data width and depth, almost-full/almost-empty thresholds, defined simultaneous read/write at the full and empty boundaries, and optional sticky overflow/underflow error flags. Pointers and occupancy count are exported so the existing property-checker style of verification can bind to them directly.

## Interface
- DATA_W, 16, data word width in bits
- ADDR_W, 4, pointer width; DEPTH = 2**ADDR_W entries (default 16)
- AFULL_TH, 12, fifo_afull asserted when cnt >= AFULL_TH (1..DEPTH)
- AEMPTY_TH, 4, fifo_aempty asserted when cnt <= AEMPTY_TH (0..DEPTH-1)

- clk  in  1  single clock, all state on posedge
- rst_  in  1  asynchronous, active-low reset
- fifo_data_in  in  DATA_W  write data
- fifo_write  in  1  write request
- fifo_read  in  1  read request
- err_clr  in  1  synchronous clear of sticky error flags
- fifo_data_out  out  DATA_W  registered read data
- fifo_full  out  1  cnt == DEPTH
- fifo_empty  out  1  cnt == 0
- fifo_afull  out  1  cnt >= AFULL_TH
- fifo_aempty  out  1  cnt <= AEMPTY_TH
- wr_ptr  out  ADDR_W  write pointer
- rd_ptr  out  ADDR_W  read pointer
- cnt  out  ADDR_W+1  occupancy, 0..DEPTH
- fifo_overflow  out  1  sticky overflow flag (see Configuration)
- fifo_underflow  out  1  sticky underflow flag (see Configuration)

## Operation
- rd_ok = fifo_read && !fifo_empty; wr_ok = fifo_write && (!fifo_full || rd_ok).
- wr_ok: mem[wr_ptr] <= fifo_data_in; wr_ptr <= wr_ptr+1 (wraps DEPTH-1 -> 0).
- rd_ok: fifo_data_out <= mem[rd_ptr]; rd_ptr <= rd_ptr+1 (wraps). No rd_ok: fifo_data_out holds.
- cnt: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither. Never exceeds DEPTH, never below 0.
- Full + write + read: both accepted, cnt stays DEPTH, both pointers advance.
- Empty + write + read: write accepted, read rejected; cnt -> 1, rd_ptr unchanged, fifo_data_out holds.
- Full + write, no read: write dropped, wr_ptr and memory unchanged.
- Empty + read: read dropped, rd_ptr and fifo_data_out unchanged.
- Flags are combinational decodes of the cnt register only (no input paths to flags).
- Overflow event: fifo_write && fifo_full && !fifo_read. Underflow event: fifo_read && fifo_empty.
- Reset (any time, including mid-burst): wr_ptr=0, rd_ptr=0, cnt=0, fifo_data_out=0, fifo_empty=1, fifo_full=0, fifo_aempty=1, fifo_afull=0, fifo_overflow=0, fifo_underflow=0. Memory contents not reset and not observable until rewritten.

## Timing
- All state updates on posedge clk; reset acts immediately on rst_ falling, release synchronous to next edge.
- Write-to-empty-deassert latency: 1 cycle (edge that accepts write).
- Read latency: data for an accepted read on edge N is valid on fifo_data_out after edge N.
- Write-to-read: word written on edge N readable by read accepted on edge N+1 or later.
- Flags, cnt, pointers all change on the same edge as the accepted operation.
- Error flags set on the edge after the event cycle; err_clr clears on next edge; set takes priority over simultaneous clear.

## Configuration
- FIFO_ERR_FLAGS_EN defined: fifo_overflow/fifo_underflow are sticky registers, set by their events, cleared only by err_clr or reset.
- Not defined: both outputs tied to 0, err_clr ignored, no error registers synthesised. All other behaviour identical.

## Test plan
- Reset: drive 5 writes, assert rst_=0 mid-cycle -> immediately cnt=0, ptrs=0, empty=1, full=0, data_out=0.
- Fill: 16 writes of 0x0000..0x000F (defaults) -> afull rises when cnt=12, full=1 at cnt=16, wr_ptr=0; 16 reads return 0x0000..0x000F in order, empty=1, aempty from cnt=4.
- Overflow: full, write 0xDEAD without read -> wr_ptr unchanged, cnt=16, fifo_overflow=1 (with macro) and stays 1 until err_clr.
- Underflow: empty, read -> rd_ptr unchanged, data_out holds previous value, fifo_underflow=1 (with macro); without macro stays 0.
- Simultaneous: at full, write+read -> cnt stays 16, both ptrs +1, oldest word out; at empty, write 0x1234+read -> cnt=1, rd_ptr unchanged; next read returns 0x1234.
- Wrap and parameters: DATA_W=8, ADDR_W=3, 20 interleaved write/read pairs -> pointers wrap 7->0, data order preserved, full at cnt=8.
